mmio_initiator: RTL and testbench

// Bus initiator for the MMIO peripheral interface (timer and other memory-mapped slaves).
// - Accepts core load/store requests into a small FIFO and drives them on the peripheral bus:

---
 rtl/mmio_initiator_pkg.sv | 22 ++
 rtl/mmio_initiator_if.sv | 40 ++++
 rtl/mmio_req_fifo.sv | 46 ++++
 rtl/mmio_initiator.sv | 165 ++++++++++++++++
 tb/tb_mmio_initiator.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_initiator_pkg.sv
// Shared types for the MMIO initiator: FSM encoding, request record and the
// read data returned on an error response.
package mmio_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_RWAIT = 2'd3
  } mmio_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mmio_req_t;

  localparam int          MMIO_REQ_W     = $bits(mmio_req_t);
  localparam logic [31:0] MMIO_ERR_RDATA = 32'h0;

endpackage

// File: rtl/mmio_initiator_if.sv
// Core request/response port plus the peripheral write/read strobe bus.
// master = the initiator's view, slave = the core + peripheral side.
interface mmio_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        wready;
  logic        wvalid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        rready;
  logic        rvalid;
  logic [31:0] raddr;
  logic        rresp;
  logic [31:0] rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  wvalid, rvalid, rresp, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output wready, waddr, wdata, wstrb, rready, raddr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output wvalid, rvalid, rresp, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  wready, waddr, wdata, wstrb, rready, raddr
  );
endinterface

// File: rtl/mmio_req_fifo.sv
// Registered synchronous FIFO; head entry is visible on pop_data while non-empty.
// Push is honoured when full as long as a pop happens in the same cycle.
module mmio_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_initiator.sv
// MMIO bus initiator: queues core loads/stores, runs one peripheral transaction
// at a time and returns exactly one response (data or timeout error) per request.
module mmio_initiator
  import mmio_initiator_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mmio_initiator_if.master  bus
);
  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  mmio_state_e state, state_nx;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nx;
  logic          timed_out;

  mmio_req_t   push_req, head;
  logic        push, pop, full, empty;

  logic        wready_q, wready_nx;
  logic        rready_q, rready_nx;
  logic [31:0] waddr_q, waddr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [3:0]  wstrb_q, wstrb_nx;
  logic [31:0] raddr_q, raddr_nx;
  logic        resp_valid_q, resp_valid_nx;
  logic [31:0] resp_rdata_q, resp_rdata_nx;
  logic        resp_err_q, resp_err_nx;

  // Gated by reset so every output reads 0 while reset is held.
  assign bus.req_ready = !full && !reset;
  assign push          = bus.req_valid && bus.req_ready;
  assign push_req      = '{we: bus.req_we, addr: bus.req_addr,
                           wdata: bus.req_wdata, wstrb: bus.req_wstrb};

  mmio_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MMIO_REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign timed_out = (tmo_cnt == TO_LAST);

  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    tmo_cnt_nx    = timed_out ? tmo_cnt : tmo_cnt + CW'(1);
    wready_nx     = wready_q;
    rready_nx     = rready_q;
    waddr_nx      = waddr_q;
    wdata_nx      = wdata_q;
    wstrb_nx      = wstrb_q;
    raddr_nx      = raddr_q;
    resp_valid_nx = 1'b0;
    resp_rdata_nx = MMIO_ERR_RDATA;
    resp_err_nx   = 1'b0;

    case (state)
      ST_IDLE: begin
        tmo_cnt_nx = '0;
        if (!empty) begin
          pop = 1'b1;
          if (head.we) begin
            wready_nx = 1'b1;
            waddr_nx  = head.addr;
            wdata_nx  = head.wdata;
            wstrb_nx  = head.wstrb;
            state_nx  = ST_WR;
          end else begin
            rready_nx = 1'b1;
            raddr_nx  = head.addr;
            state_nx  = ST_RD;
          end
        end
      end
      // Completion is tested before the timeout so a coinciding handshake wins.
      ST_WR: begin
        if (bus.wvalid) begin
          wready_nx     = 1'b0;
          resp_valid_nx = 1'b1;
          state_nx      = ST_IDLE;
        end else if (timed_out) begin
          wready_nx     = 1'b0;
          resp_valid_nx = 1'b1;
          resp_err_nx   = 1'b1;
          state_nx      = ST_IDLE;
        end
      end
      ST_RD: begin
        if (bus.rvalid) begin
          rready_nx  = 1'b0;
          tmo_cnt_nx = '0;
          state_nx   = ST_RWAIT;
        end else if (timed_out) begin
          rready_nx     = 1'b0;
          resp_valid_nx = 1'b1;
          resp_err_nx   = 1'b1;
          state_nx      = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        if (bus.rresp) begin
          resp_valid_nx = 1'b1;
          resp_rdata_nx = bus.rdata;
          state_nx      = ST_IDLE;
        end else if (timed_out) begin
          resp_valid_nx = 1'b1;
          resp_err_nx   = 1'b1;
          state_nx      = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      wready_q     <= 1'b0;
      rready_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      raddr_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_nx;
      tmo_cnt      <= tmo_cnt_nx;
      wready_q     <= wready_nx;
      rready_q     <= rready_nx;
      waddr_q      <= waddr_nx;
      wdata_q      <= wdata_nx;
      wstrb_q      <= wstrb_nx;
      raddr_q      <= raddr_nx;
      resp_valid_q <= resp_valid_nx;
      resp_rdata_q <= resp_rdata_nx;
      resp_err_q   <= resp_err_nx;
    end
  end

  assign bus.wready     = wready_q;
  assign bus.rready     = rready_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.raddr      = raddr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator: scoreboard of expected responses (data,
// error, arrival cycle) pushed on acceptance and popped when resp_valid fires.
module tb_mmio_initiator;
  import mmio_initiator_pkg::*;

  localparam int          DEPTH         = 2;
  localparam int          TIMEOUT       = 16;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_0100;
  localparam logic [31:0] MTIME_BASE    = 32'h0000_0108;

  logic clk = 1'b0;
  logic reset;

  mmio_initiator_if bus();

  mmio_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Slave model: accepts while enabled, returns rresp one cycle after the
  // read handshake with rdata = raddr ^ rkey.
  logic        w_ok, r_ok, resp_ok;
  logic [31:0] rkey;
  assign bus.wvalid = bus.wready & w_ok;
  assign bus.rvalid = bus.rready & r_ok;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rresp <= 1'b0;
      bus.rdata <= 32'h0;
    end else begin
      bus.rresp <= bus.rready & bus.rvalid & resp_ok;
      bus.rdata <= bus.raddr ^ rkey;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("strobe_exclusive", {31'b0, bus.wready & bus.rready}, 32'h0);
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_resp", {31'b0, bus.resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
        if (e.due >= 0) check("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  // lat < 0: do not check arrival cycle; track=0: no response is expected.
  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] erd, input logic eerr,
                          input int lat, input bit track);
    exp_t e;
    int   n;
    n             = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      check("req_accept_timeout", {31'b0, bus.req_ready}, 32'h1);
    end else if (track) begin
      e.rdata = erd;
      e.err   = eerr;
      e.due   = (lat < 0) ? -1 : cyc + 1 + lat;
      sb.push_back(e);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    w_ok          = 1'b1;
    r_ok          = 1'b1;
    resp_ok       = 1'b1;
    rkey          = 32'h0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    check("rst_wready", {31'b0, bus.wready}, 32'h0);
    check("rst_rready", {31'b0, bus.rready}, 32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_waddr", bus.waddr, 32'h0);
    check("rst_raddr", bus.raddr, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("req_ready_after_reset", {31'b0, bus.req_ready}, 32'h1);

    // 1: write, slave always accepts -> wready cycle 1, response cycle 2
    push_req(1'b1, MTIMECMP_BASE, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 2, 1'b1);
    tick();
    check("t1_wready", {31'b0, bus.wready}, 32'h1);
    check("t1_waddr", bus.waddr, MTIMECMP_BASE);
    check("t1_wdata", bus.wdata, 32'hCAFE_0001);
    check("t1_wstrb", {28'b0, bus.wstrb}, 32'hF);
    tick();
    check("t1_wready_drop", {31'b0, bus.wready}, 32'h0);
    tick();
    check("t1_waddr_hold", bus.waddr, MTIMECMP_BASE);
    drain();

    // 2: read, rresp one cycle after handshake -> response cycle 3
    rkey = MTIME_BASE ^ 32'h0000_1234;
    push_req(1'b0, MTIME_BASE, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 3, 1'b1);
    tick();
    check("t2_rready", {31'b0, bus.rready}, 32'h1);
    check("t2_raddr", bus.raddr, MTIME_BASE);
    drain();

    // 3: stall first read, fill FIFO, next request blocked until a pop
    rkey = 32'h5A5A_0000;
    r_ok = 1'b0;
    push_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h10 ^ 32'h5A5A_0000, 1'b0, -1, 1'b1);
    push_req(1'b1, 32'h20, 32'h2222, 4'hF, 32'h0, 1'b0, -1, 1'b1);
    push_req(1'b0, 32'h30, 32'h0, 4'h0, 32'h30 ^ 32'h5A5A_0000, 1'b0, -1, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    for (int i = 0; i < 3; i++) begin
      check("t3_req_ready_full", {31'b0, bus.req_ready}, 32'h0);
      tick();
    end
    r_ok = 1'b1;
    push_req(1'b1, 32'h40, 32'h4444, 4'h3, 32'h0, 1'b0, -1, 1'b1);
    drain();

    // 4: rresp never comes -> error TIMEOUT cycles after RWAIT entry; queued write follows
    resp_ok = 1'b0;
    push_req(1'b0, 32'h50, 32'h0, 4'h0, MMIO_ERR_RDATA, 1'b1, TIMEOUT + 2, 1'b1);
    push_req(1'b1, 32'h60, 32'h6666, 4'hF, 32'h0, 1'b0, TIMEOUT + 3, 1'b1);
    drain();
    resp_ok = 1'b1;

    // 5: wvalid low for 5 cycles, then high
    w_ok = 1'b0;
    push_req(1'b1, 32'h70, 32'h7777, 4'h5, 32'h0, 1'b0, 7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_wready_hold", {31'b0, bus.wready}, 32'h1);
    end
    w_ok = 1'b1;
    drain();

    // 6: reset during RWAIT with one queued request; neither ever responds
    resp_ok = 1'b0;
    push_req(1'b0, 32'h80, 32'h0, 4'h0, 32'h0, 1'b0, -1, 1'b0);
    push_req(1'b0, 32'h90, 32'h0, 4'h0, 32'h0, 1'b0, -1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("t6_rst_rready", {31'b0, bus.rready}, 32'h0);
    check("t6_rst_wready", {31'b0, bus.wready}, 32'h0);
    check("t6_rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    check("t6_rst_raddr", bus.raddr, 32'h0);
    check("t6_rst_resp_rdata", bus.resp_rdata, 32'h0);
    tick();
    tick();
    reset   = 1'b0;
    resp_ok = 1'b1;
    for (int i = 0; i < TIMEOUT + 6; i++) tick();
    check("t6_rready_idle", {31'b0, bus.rready}, 32'h0);
    check("t6_req_ready", {31'b0, bus.req_ready}, 32'h1);
    rkey = 32'h0F0F_0000;
    push_req(1'b0, 32'hA0, 32'h0, 4'h0, 32'hA0 ^ 32'h0F0F_0000, 1'b0, 3, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
